// File: rtl/fu_result_buffer_pkg.sv
// Shared types and constants for the per-FU result buffer feeding the common data bus.
package fu_result_buffer_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 4;
    localparam int FU_NUM      = 4;

    // FU_BTU must match the CDB's select index for the branch unit
    localparam logic [1:0] FU_ALU  = 2'd0;
    localparam logic [1:0] FU_MULT = 2'd1;
    localparam logic [1:0] FU_LSU  = 2'd2;
    localparam logic [1:0] FU_BTU  = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]        value;
        logic [ROB_TAG_LEN-1:0] tag;
        logic                   mis_predict;
        logic [XLEN-1:0]        target_pc;
    } fu_result_t;

endpackage

// File: rtl/fu_result_buffer_fifo.sv
// Generic DEPTH-entry synchronous FIFO of fu_result_t; clear and reset empty it at the next edge.
module result_fifo
    import fu_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         push,
    input  fu_result_t                   push_data,
    input  logic                         pop,
    output fu_result_t                   head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fu_result_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[head];

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset; entries are only read while count is non-zero
    always_ff @(posedge clock) begin
        if (reset_n && !clear && do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fu_result_buffer.sv
// Per-FU CDB transmit stage: queues results, holds the head until granted.
// Optional macro FU_RESULT_BYPASS_EN forwards a push into an empty buffer in the same cycle.
module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int FU_ID  = 0,
    parameter int DEPTH  = 4,
    parameter int IS_BTU = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        in_value,
    input  logic [ROB_TAG_LEN-1:0] in_tag,
    input  logic                   in_mis_predict,
    input  logic [XLEN-1:0]        in_target_pc,
    output logic                   in_ready,
    input  logic                   squash,
    input  logic                   cdb_rob_enable,
    input  logic [1:0]             cdb_select_fu,
    output logic                   fu_result_ready,
    output logic [XLEN-1:0]        fu_result,
    output logic [ROB_TAG_LEN-1:0] fu_tag,
    output logic                   fu_mis_predict,
    output logic [XLEN-1:0]        fu_target_pc
);

    localparam int CNT_W = $clog2(DEPTH+1);

    fu_result_t       in_entry;
    fu_result_t       head_entry;
    fu_result_t       out_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             push_ok;
    logic             grant;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;

    assign in_entry = '{value: in_value, tag: in_tag,
                        mis_predict: in_mis_predict, target_pc: in_target_pc};

    // in_ready depends on registered count only, keeping the CDB grant path acyclic
    assign in_ready = (fifo_count != CNT_W'(DEPTH));
    assign push_ok  = in_valid && in_ready;
    assign grant    = fu_result_ready && cdb_rob_enable && (cdb_select_fu == 2'(FU_ID));

`ifdef FU_RESULT_BYPASS_EN
    assign bypass = (fifo_count == '0) && push_ok && !squash;
`else
    assign bypass = 1'b0;
`endif

    assign fu_result_ready = (fifo_count != '0) || bypass;
    assign fifo_push       = push_ok && !(bypass && grant);
    assign fifo_pop        = grant && (fifo_count != '0);

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (squash),
        .push      (fifo_push),
        .push_data (in_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    always_comb begin
        out_entry = '0;
        if (bypass)
            out_entry = in_entry;
        else if (fifo_count != '0)
            out_entry = head_entry;
        if (IS_BTU == 0) begin
            out_entry.mis_predict = 1'b0;
            out_entry.target_pc   = '0;
        end
    end

    assign fu_result      = out_entry.value;
    assign fu_tag         = out_entry.tag;
    assign fu_mis_predict = out_entry.mis_predict;
    assign fu_target_pc   = out_entry.target_pc;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer: an ALU-slot instance (IS_BTU=0) and a BTU-slot instance.
module tb_fu_result_buffer;
    import fu_result_buffer_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   in_valid, in_valid_b;
    logic [XLEN-1:0]        in_value;
    logic [ROB_TAG_LEN-1:0] in_tag;
    logic                   in_mis_predict;
    logic [XLEN-1:0]        in_target_pc;
    logic                   squash;
    logic                   cdb_rob_enable;
    logic [1:0]             cdb_select_fu;

    logic                   in_ready, in_ready_b;
    logic                   rdy, rdy_b;
    logic [XLEN-1:0]        res, res_b;
    logic [ROB_TAG_LEN-1:0] tag, tag_b;
    logic                   mis, mis_b;
    logic [XLEN-1:0]        tpc, tpc_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fu_result_buffer #(.FU_ID(0), .DEPTH(4), .IS_BTU(0)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_value(in_value),
        .in_tag(in_tag), .in_mis_predict(in_mis_predict), .in_target_pc(in_target_pc),
        .in_ready(in_ready), .squash(squash), .cdb_rob_enable(cdb_rob_enable),
        .cdb_select_fu(cdb_select_fu), .fu_result_ready(rdy), .fu_result(res),
        .fu_tag(tag), .fu_mis_predict(mis), .fu_target_pc(tpc)
    );

    fu_result_buffer #(.FU_ID(3), .DEPTH(4), .IS_BTU(1)) dut_btu (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_b), .in_value(in_value),
        .in_tag(in_tag), .in_mis_predict(in_mis_predict), .in_target_pc(in_target_pc),
        .in_ready(in_ready_b), .squash(squash), .cdb_rob_enable(cdb_rob_enable),
        .cdb_select_fu(cdb_select_fu), .fu_result_ready(rdy_b), .fu_result(res_b),
        .fu_tag(tag_b), .fu_mis_predict(mis_b), .fu_target_pc(tpc_b)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic grant_check(input string name, input logic [3:0] exp_tag);
        cdb_rob_enable = 1'b1;
        cdb_select_fu  = 2'd0;
        settle();
        chk({name, "_rdy"}, 32'(rdy), 32'd1);
        chk({name, "_tag"}, 32'(tag), 32'(exp_tag));
        step();
        cdb_rob_enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; in_value = '0; in_tag = '0;
        in_mis_predict = 1'b0; in_target_pc = '0; squash = 1'b0;
        cdb_rob_enable = 1'b0; cdb_select_fu = 2'd0;

        // reset and basic transfer
        step(); step();
        reset_n = 1'b1;
        settle();
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", res, 32'd0);
        chk("rst_tag", 32'(tag), 32'd0);
        in_valid = 1'b1; in_value = 32'h1234; in_tag = 4'd5;
        settle();
`ifndef FU_RESULT_BYPASS_EN
        chk("push_rdy_same_cycle", 32'(rdy), 32'd0);
`endif
        step();
        in_valid = 1'b0;
        settle();
        chk("basic_rdy", 32'(rdy), 32'd1);
        chk("basic_value", res, 32'h1234);
        chk("basic_tag", 32'(tag), 32'd5);
        cdb_rob_enable = 1'b1; cdb_select_fu = 2'd0;
        step();
        cdb_rob_enable = 1'b0;
        settle();
        chk("basic_after_grant_rdy", 32'(rdy), 32'd0);
        chk("basic_after_grant_value", res, 32'd0);

        // lost arbitration: another FU wins for 5 cycles
        cdb_rob_enable = 1'b1; cdb_select_fu = 2'd1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_tag   = 4'(i + 1);
            in_value = 32'h100 + 32'(i);
            step();
        end
        in_valid = 1'b0; cdb_rob_enable = 1'b0;
        settle();
        chk("lost_head_tag", 32'(tag), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("lost_value", res, 32'h100 + 32'(k));
            grant_check("lost", 4'(k + 1));
        end
        chk("lost_drained", 32'(rdy), 32'd0);

        // full and backpressure
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_tag   = 4'(8 + i);
            in_value = 32'(i);
            settle();
            chk("full_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        settle();
        chk("full_count", 32'(dut.fifo_count), 32'd4);
        chk("full_in_ready_hold", 32'(in_ready), 32'd0);
        grant_check("full_pop", 4'd8);
        settle();
        chk("full_reopen", 32'(in_ready), 32'd1);
        chk("full_count_after", 32'(dut.fifo_count), 32'd3);
        grant_check("full_drain", 4'd9);
        grant_check("full_drain", 4'd10);
        grant_check("full_drain", 4'd11);
        chk("full_fifth_dropped", 32'(rdy), 32'd0);

        // simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_tag = 4'(6 + i);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_tag = 4'(i);
            cdb_rob_enable = 1'b1; cdb_select_fu = 2'd0;
            settle();
            chk("pp_head", 32'(tag), 32'(6 + i));
            step();
            chk("pp_count", 32'(dut.fifo_count), 32'd2);
        end
        in_valid = 1'b0; cdb_rob_enable = 1'b0;
        grant_check("pp_wrap", 4'd0);
        grant_check("pp_wrap", 4'd1);
        chk("pp_drained", 32'(rdy), 32'd0);

        // squash with count 3, concurrent push and grant
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_tag = 4'(2 + i);
            step();
        end
        chk("sq_pre_count", 32'(dut.fifo_count), 32'd3);
        squash = 1'b1; in_valid = 1'b1; in_tag = 4'd9;
        cdb_rob_enable = 1'b1; cdb_select_fu = 2'd0;
        step();
        squash = 1'b0; in_valid = 1'b0; cdb_rob_enable = 1'b0;
        settle();
        chk("sq_rdy", 32'(rdy), 32'd0);
        chk("sq_count", 32'(dut.fifo_count), 32'd0);
        chk("sq_in_ready", 32'(in_ready), 32'd1);
        step(); step();
        chk("sq_stays_empty", 32'(rdy), 32'd0);
        in_valid = 1'b1; in_tag = 4'd5;
        step();
        in_valid = 1'b0;
        grant_check("sq_next_push", 4'd5);
        chk("sq_final_empty", 32'(rdy), 32'd0);

        // BTU fields and masking; BTU instance is granted via select 3
        in_valid = 1'b1; in_valid_b = 1'b1; in_tag = 4'd3; in_value = 32'h55;
        in_mis_predict = 1'b1; in_target_pc = 32'h80;
        cdb_rob_enable = 1'b1; cdb_select_fu = FU_BTU;
        settle();
`ifdef FU_RESULT_BYPASS_EN
        chk("byp_rdy", 32'(rdy_b), 32'd1);
        chk("byp_tpc", tpc_b, 32'h80);
        chk("byp_mis", 32'(mis_b), 32'd1);
        step();
        in_valid = 1'b0; in_valid_b = 1'b0;
        settle();
        chk("byp_empty_after", 32'(rdy_b), 32'd0);
        chk("byp_count_after", 32'(dut_btu.fifo_count), 32'd0);
`else
        chk("btu_rdy_same_cycle", 32'(rdy_b), 32'd0);
        step();
        in_valid = 1'b0; in_valid_b = 1'b0;
        settle();
        chk("btu_rdy", 32'(rdy_b), 32'd1);
        chk("btu_tpc", tpc_b, 32'h80);
        chk("btu_mis", 32'(mis_b), 32'd1);
        step();
        chk("btu_empty_after", 32'(rdy_b), 32'd0);
`endif
        cdb_rob_enable = 1'b0;
        settle();
        chk("alu_mask_rdy", 32'(rdy), 32'd1);
        chk("alu_mask_mis", 32'(mis), 32'd0);
        chk("alu_mask_tpc", tpc, 32'd0);
        chk("alu_mask_value", res, 32'h55);
        grant_check("alu_mask_pop", 4'd3);

        // reset mid-operation
        in_valid = 1'b1; in_tag = 4'd7;
        step(); step();
        in_valid = 1'b0; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_rdy", 32'(rdy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_tag", 32'(tag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_result_buffer.md
Name: fu_result_buffer

Overview:
- Per-FU output stage; the transmit side of the common data bus (CDB).
- Queues completed FU results (value, ROB tag, branch outcome) and presents the head entry to the CDB as a ready/value/tag triple.
- Holds the head until the CDB selects this FU; a lost arbitration never drops a result.
- One instance per FU. The FU stalls on in_ready low.

Parameters:
- FU_ID, 0, this FU's index on the CDB; compared against the CDB's select_fu.
- DEPTH, 4, entries per buffer; power of two, at least 2.
- IS_BTU, 0, 1 means mis_predict and target_pc are stored; 0 means they are forced to 0.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  FU has a completed result this cycle
- in_value  in  XLEN  result value
- in_tag  in  ROB_TAG_LEN  destination ROB tag
- in_mis_predict  in  1  branch mispredicted (BTU only)
- in_target_pc  in  XLEN  corrected branch target (BTU only)
- in_ready  out  1  buffer can accept a push this cycle
- squash  in  1  pipeline flush; discard all entries
- cdb_rob_enable  in  1  CDB broadcast valid this cycle
- cdb_select_fu  in  2  FU index the CDB broadcast this cycle
- fu_result_ready  out  1  head entry valid; feeds the CDB's per-FU ready bit
- fu_result  out  XLEN  head value
- fu_tag  out  ROB_TAG_LEN  head ROB tag
- fu_mis_predict  out  1  head mispredict flag
- fu_target_pc  out  XLEN  head target PC

Behaviour:
- Storage: circular FIFO with head/tail pointers of width $clog2(DEPTH) that wrap naturally, and a count of width $clog2(DEPTH+1).
- in_ready = (count != DEPTH). It is registered-state only and does not depend on grant in the same cycle, so no combinational loop through the CDB.
- push = in_valid && in_ready. If in_valid is high while full, the input is ignored; the FU must hold it.
- grant = fu_result_ready && cdb_rob_enable && (cdb_select_fu == FU_ID).
  - pop = grant.
  - Pop advances head at the clock edge; the next entry appears the following cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, a same-cycle pop does not open in_ready; one bubble is accepted.
- Outputs:
  - fu_result_ready = (count != 0); the head fields are valid only while it is high.
  - While empty, all data outputs are 0.
  - IS_BTU = 0 forces fu_mis_predict and fu_target_pc to 0.
- Ordering: strict FIFO. The CDB's static priority may starve this FU; the buffer holds indefinitely and the FU stalls through in_ready.
- squash:
  - Next cycle: count = 0, head = tail = 0, fu_result_ready = 0.
  - Any push or pop in the squash cycle is discarded and squash has priority.
  - A grant in the squash cycle still counts as broadcast to the CDB; the CDB side ignores it.
- Reset (reset_n = 0 at an edge, including mid-operation): same state as squash. All outputs are 0 and in_ready = 1 from the next cycle.
- Latency:
  - Push to fu_result_ready is 1 cycle.
  - Grant to next head is 1 cycle.
  - Throughput is 1 result per cycle when granted every cycle.

Optional Feature:
- Macro: FU_RESULT_BYPASS_EN.
- Defined:
  - When count == 0 and push, the input fields drive the outputs combinationally the same cycle with fu_result_ready = 1.
  - If granted that cycle, the entry is not written (zero-latency forwarding); otherwise it is written normally.
  - squash blocks the bypass.
- Undefined: the 1-cycle latency above applies.

Decomposition:
- Shared package:
  - fu_result_t struct {value, tag, mis_predict, target_pc}.
  - FU index constants (FU_ALU, FU_MULT, FU_LSU, FU_BTU), with FU_BTU matching the CDB's BTU select index.
  - FU_NUM = 4.
- One sub-module: result_fifo, a generic DEPTH-entry synchronous FIFO of fu_result_t with push, pop, clear, count and head.
- The wrapper adds the grant decode, IS_BTU masking and bypass.

Test Plan:
- Reset and basic transfer: reset_n low 2 cycles then high; push value 0x1234, tag 5; grant on the next cycle.
  - Required: fu_result_ready rises 1 cycle after the push, then falls after the grant cycle.
  - Required: fu_result = 0x1234 and fu_tag = 5 while ready.
- Lost arbitration: push tags 1, 2, 3 while cdb_select_fu != FU_ID for 5 cycles, then grant 3 consecutive cycles.
  - Required: heads present tags 1, 2, 3 in order; nothing is lost.
- Full and backpressure (DEPTH = 4): push 5 consecutive cycles with no grant.
  - Required: in_ready = 0 after the 4th push; the 5th is not accepted; count = 4.
  - Then one grant: in_ready returns to 1 the next cycle.
- Simultaneous push and pop at count 2:
  - Required: count stays 2 and order is preserved across the pointer wrap (tags 6, 7, 0, 1).
- Squash mid-operation: count 3, then squash together with in_valid and a grant.
  - Required: fu_result_ready = 0 next cycle, count = 0, in_ready = 1, and the dropped push never appears.
- BTU and bypass: IS_BTU = 1, FU_RESULT_BYPASS_EN defined; push mis_predict = 1, target_pc 0x80 into an empty buffer with same-cycle grant.
  - Required: same-cycle fu_result_ready = 1 and fu_target_pc = 0x80; the buffer stays empty afterwards.
  - With IS_BTU = 0: fu_mis_predict = 0 and fu_target_pc = 0.
